// File: rtl/periph_bus_master_pkg.sv
// rtl/periph_bus_master_pkg.sv - FSM state type and peripheral address map for the bus master
package periph_bus_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic [31:0] ADDR_BASE_DEFAULT = 32'h4000_0000;

   localparam logic [31:0] OFS_TH     = 32'h00;
   localparam logic [31:0] OFS_TL     = 32'h04;
   localparam logic [31:0] OFS_TCON   = 32'h08;
   localparam logic [31:0] OFS_LED    = 32'h0C;
   localparam logic [31:0] OFS_SWITCH = 32'h10;
   localparam logic [31:0] OFS_DIGI   = 32'h14;

   // DIGI is the highest mapped register, so it bounds the default window
   localparam logic [31:0] ADDR_LAST_DEFAULT = ADDR_BASE_DEFAULT + OFS_DIGI;

   function automatic logic addr_ok(input logic [31:0] a,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
      return (a >= lo) && (a <= hi) && (a[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/periph_bus_master_irq_edge_latch.sv
// rtl/periph_bus_master_irq_edge_latch.sv - rising-edge detect on irqout with sticky pending flag
module irq_edge_latch (
   input  logic clk,
   input  logic reset,
   input  logic irqout,
   input  logic irq_ack,
   output logic irq_pending
);

   logic irq_prev;
   logic rise;

   assign rise = irqout & ~irq_prev;

   // a fresh edge outranks an ack in the same cycle so no interrupt is lost
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_prev    <= 1'b0;
         irq_pending <= 1'b0;
      end else begin
         irq_prev <= irqout;
         if (rise)
            irq_pending <= 1'b1;
         else if (irq_ack)
            irq_pending <= 1'b0;
      end
   end

endmodule

// File: rtl/periph_bus_master.sv
// rtl/periph_bus_master.sv - single-outstanding load/store initiator for the peripheral bus
module periph_bus_master
   import periph_bus_master_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEFAULT,
   parameter logic [31:0] ADDR_LAST   = ADDR_LAST_DEFAULT,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        rd,
   output logic        wr,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   input  logic [31:0] rdata,
   input  logic        irqout,
   output logic        irq_pending,
   input  logic        irq_ack
);

   localparam logic [15:0] CNT_INIT = 16'(WAIT_CYCLES - 1);

   state_t      state, state_nx;
   logic        we_q;
   logic [15:0] cnt;
   logic        last;
   logic        req_ok;

   assign last   = (cnt == 16'd0);
   assign req_ok = addr_ok(req_addr, ADDR_BASE, ADDR_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         we_q       <= 1'b0;
         addr       <= 32'h0;
         wdata      <= 32'h0;
         cnt        <= 16'd0;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  we_q       <= req_we;
                  addr       <= req_addr;
                  wdata      <= req_wdata;
                  cnt        <= CNT_INIT;
                  resp_rdata <= 32'h0;
                  resp_err   <= ~req_ok;
               end
            end
            ST_ACCESS: begin
               if (!last)
                  cnt <= cnt - 16'd1;
               else if (!we_q)
                  resp_rdata <= rdata;
            end
            default: ;
         endcase
      end
   end

   // rd/wr/resp_valid decode only registered state, never request inputs
   always_comb begin
      state_nx   = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      rd         = 1'b0;
      wr         = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid)
               state_nx = req_ok ? ST_ACCESS : ST_RESP;
         end
         ST_ACCESS: begin
            rd = ~we_q;
            wr = we_q & last;
            if (last)
               state_nx = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            state_nx   = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   irq_edge_latch u_irq (
      .clk         (clk),
      .reset       (reset),
      .irqout      (irqout),
      .irq_ack     (irq_ack),
      .irq_pending (irq_pending)
   );

endmodule
